// File: rtl/pong_pkg.sv
// pong_pkg: FSM state codes and readout select codes for pong_engine.
// Build with PONG_SCORE_EN defined to include score keeping and the OVER state.
package pong_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SERVE = 2'd1;
  localparam state_t ST_PLAY  = 2'd2;
  localparam state_t ST_OVER  = 2'd3;

  localparam logic [2:0] SEL_BX   = 3'd0;
  localparam logic [2:0] SEL_BY   = 3'd1;
  localparam logic [2:0] SEL_LP   = 3'd2;
  localparam logic [2:0] SEL_RP   = 3'd3;
  localparam logic [2:0] SEL_LS   = 3'd4;
  localparam logic [2:0] SEL_RS   = 3'd5;
  localparam logic [2:0] SEL_ST   = 3'd6;
  localparam logic [2:0] SEL_ZERO = 3'd7;

endpackage

// File: rtl/pong_paddle.sv
// pong_paddle: one paddle row register, stepped on tick and
// saturated so the whole paddle stays on the playfield.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int SCREEN_H    = 187,
  parameter int PADDLE_EXT  = 5,
  parameter int PADDLE_STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               up,
  input  logic               dn,
  output logic [COORD_W-1:0] y
);

  localparam logic [COORD_W:0] Y_LO =
    (COORD_W+1)'(PADDLE_EXT);
  localparam logic [COORD_W:0] Y_HI =
    (COORD_W+1)'(SCREEN_H - 1 - PADDLE_EXT);
  localparam logic [COORD_W:0] STEP =
    (COORD_W+1)'(PADDLE_STEP);

  logic [COORD_W:0]   yw;
  logic [COORD_W-1:0] nxt;

  assign yw = {1'b0, y};

  // one guard bit keeps the add/subtract from wrapping
  always_comb begin
    nxt = y;
    if (up && !dn)
      nxt = (yw < Y_LO + STEP) ? COORD_W'(Y_LO)
                               : COORD_W'(yw - STEP);
    else if (dn && !up)
      nxt = (yw + STEP > Y_HI) ? COORD_W'(Y_HI)
                               : COORD_W'(yw + STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      y <= COORD_W'(SCREEN_H / 2);
    else if (tick)
      y <= nxt;
  end

endmodule

// File: rtl/pong_engine.sv
// pong_engine: ball/paddle game state machine with registered readout.
// Define PONG_SCORE_EN to keep scores and stop the game at WIN_SCORE.
module pong_engine
  import pong_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int SCREEN_W    = 200,
  parameter int SCREEN_H    = 187,
  parameter int PADDLE_EXT  = 5,
  parameter int PADDLE_STEP = 1,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               serve_i,
  input  logic               lp_up_i,
  input  logic               lp_dn_i,
  input  logic               rp_up_i,
  input  logic               rp_dn_i,
  input  logic [2:0]         sel_i,
  output logic [COORD_W-1:0] data_o,
  output logic [1:0]         state_o,
  output logic               point_o,
  output logic               point_side_o
);

  if (SCREEN_W > 2**COORD_W || SCREEN_H > 2**COORD_W)
    begin : g_bad_screen
      $error("pong_engine: screen does not fit COORD_W");
    end
  if (2*PADDLE_EXT + 1 >= SCREEN_H) begin : g_bad_paddle
    $error("pong_engine: paddle too tall for screen");
  end
  if (WIN_SCORE >= 2**SCORE_W || WIN_SCORE < 1)
    begin : g_bad_score
      $error("pong_engine: WIN_SCORE does not fit SCORE_W");
    end

  localparam logic [COORD_W-1:0] X_MID = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] Y_MID = COORD_W'(SCREEN_H / 2);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] X_L   = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_R   = COORD_W'(SCREEN_W - 2);
  localparam logic [COORD_W:0]   EXT_W = (COORD_W+1)'(PADDLE_EXT);

  state_t             state, state_n;
  logic [COORD_W-1:0] bx, by, bx_n, by_n;
  logic [COORD_W-1:0] lp_y, rp_y;
  logic               vx_neg, vy_neg, vx_n, vy_n;
  logic               serve_neg, serve_n;
  logic               pt, pt_side, win, centre;
  logic [COORD_W:0]   dl, dr;
  logic               hit_l, hit_r;
  logic [COORD_W-1:0] rd;

`ifdef PONG_SCORE_EN
  localparam logic [SCORE_W-1:0] WIN_M1 = SCORE_W'(WIN_SCORE - 1);
  logic [SCORE_W-1:0] ls_q, rs_q;
`endif

  pong_paddle #(
    .COORD_W(COORD_W), .SCREEN_H(SCREEN_H),
    .PADDLE_EXT(PADDLE_EXT), .PADDLE_STEP(PADDLE_STEP)
  ) u_lp (
    .clk(clk), .rst_n(rst_n), .tick(tick_i),
    .up(lp_up_i), .dn(lp_dn_i), .y(lp_y)
  );

  pong_paddle #(
    .COORD_W(COORD_W), .SCREEN_H(SCREEN_H),
    .PADDLE_EXT(PADDLE_EXT), .PADDLE_STEP(PADDLE_STEP)
  ) u_rp (
    .clk(clk), .rst_n(rst_n), .tick(tick_i),
    .up(rp_up_i), .dn(rp_dn_i), .y(rp_y)
  );

  assign dl = (by >= lp_y) ? {1'b0, by} - {1'b0, lp_y}
                           : {1'b0, lp_y} - {1'b0, by};
  assign dr = (by >= rp_y) ? {1'b0, by} - {1'b0, rp_y}
                           : {1'b0, rp_y} - {1'b0, by};
  assign hit_l = (bx == X_L) && vx_neg && (dl <= EXT_W);
  assign hit_r = (bx == X_R) && !vx_neg && (dr <= EXT_W);

  always_comb begin
    state_n = state;
    bx_n    = bx;
    by_n    = by;
    vx_n    = vx_neg;
    vy_n    = vy_neg;
    serve_n = serve_neg;
    pt      = 1'b0;
    pt_side = 1'b0;
    win     = 1'b0;
    centre  = 1'b0;
    case (state)
      ST_IDLE: if (serve_i) begin
        state_n = ST_PLAY;
        centre  = 1'b1;
      end
      ST_SERVE: if (serve_i) state_n = ST_PLAY;
      ST_OVER: if (serve_i) begin
        state_n = ST_SERVE;
        centre  = 1'b1;
      end
      default: if (tick_i) begin
        if (bx == '0 || bx == X_MAX) begin
          pt      = 1'b1;
          pt_side = (bx == '0);
          serve_n = pt_side;
`ifdef PONG_SCORE_EN
          win = pt_side ? (rs_q == WIN_M1) : (ls_q == WIN_M1);
`endif
          state_n = win ? ST_OVER : ST_SERVE;
          centre  = !win;
        end else begin
          vy_n = (by == '0)   ? 1'b0 :
                 (by == Y_MAX) ? 1'b1 : vy_neg;
          vx_n = hit_l ? 1'b0 : hit_r ? 1'b1 : vx_neg;
          bx_n = vx_n ? bx - COORD_W'(1) : bx + COORD_W'(1);
          by_n = vy_n ? by - COORD_W'(1) : by + COORD_W'(1);
        end
      end
    endcase
    // serve always launches toward whoever lost the last point
    if (centre) begin
      bx_n = X_MID;
      by_n = Y_MID;
      vx_n = serve_n;
      vy_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bx           <= X_MID;
      by           <= Y_MID;
      vx_neg       <= 1'b0;
      vy_neg       <= 1'b0;
      serve_neg    <= 1'b0;
      point_o      <= 1'b0;
      point_side_o <= 1'b0;
    end else begin
      state     <= state_n;
      bx        <= bx_n;
      by        <= by_n;
      vx_neg    <= vx_n;
      vy_neg    <= vy_n;
      serve_neg <= serve_n;
      point_o   <= pt;
      if (pt) point_side_o <= pt_side;
    end
  end

`ifdef PONG_SCORE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_q <= '0;
      rs_q <= '0;
    end else if (state == ST_OVER && serve_i) begin
      ls_q <= '0;
      rs_q <= '0;
    end else if (pt) begin
      if (pt_side) rs_q <= rs_q + SCORE_W'(1);
      else         ls_q <= ls_q + SCORE_W'(1);
    end
  end
`endif

  always_comb begin
    rd = '0;
    unique case (1'b1)
      sel_i == SEL_BX: rd = bx;
      sel_i == SEL_BY: rd = by;
      sel_i == SEL_LP: rd = lp_y;
      sel_i == SEL_RP: rd = rp_y;
`ifdef PONG_SCORE_EN
      sel_i == SEL_LS: rd = COORD_W'(ls_q);
      sel_i == SEL_RS: rd = COORD_W'(rs_q);
`endif
      sel_i == SEL_ST: rd = COORD_W'(state);
      default:         rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_o <= '0;
    else        data_o <= rd;
  end

  assign state_o = state;

endmodule
